// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state codes,
// the debug view of the datapath, and a ceil-log2 helper for counter sizing.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [1:0] state;
        logic       carry;
    } dbg_t;

    // Returns at least 1 so a counter declared with it is never zero-width.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/serial_addsub_nbit_if.sv
// Handshake and serial data bundle of serial_addsub_nbit; the ovf signal
// exists only when SERIAL_OVF_EN is defined.
interface serial_addsub_nbit_if #(
    parameter int WIDTH = 8
);
    // start is a request sampled on a rising edge; it is taken only while the
    // block is not busy. done is a single-cycle pulse and s_out/c_out stay
    // valid from that pulse until the next accepted start.
    logic             start;
    logic             sub;
    logic             a;
    logic             b;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
    logic             busy;
    logic             done;
`ifdef SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, sub, a, b,
        input  s_out, c_out, busy, done
`ifdef SERIAL_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, sub, a, b,
        output s_out, c_out, busy, done
`ifdef SERIAL_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_fa_cell.sv
// One full-adder bit with a registered carry; load presets the carry so the
// same cell performs two's-complement subtraction when preset to 1.
module serial_fa_cell (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout,
    output logic carry
);

    assign sum  = a ^ b ^ carry;
    assign cout = (a & b) | (a & carry) | (b & carry);

    always_ff @(posedge clk) begin
        if (reset) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= load_val;
        end else if (en) begin
            carry <= cout;
        end
    end

endmodule

// File: rtl/serial_addsub_nbit.sv
// WIDTH-generic bit-serial adder/subtractor with start/done handshake.
// Optional signed-overflow flag enabled by defining SERIAL_OVF_EN.
module serial_addsub_nbit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_addsub_nbit_if.slave  bus,
    output dbg_t                 dbg
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          sub_q;
    logic          accept;
    logic          run;
    logic          bb;
    logic          sum;
    logic          cout;
    logic          carry_q;

    // start is ignored while an operation is in flight.
    assign accept = bus.start && (state != ST_RUN);
    assign run    = (state == ST_RUN);
    assign bb     = bus.b ^ sub_q;

    serial_fa_cell u_fa (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (bus.sub),
        .en       (run),
        .a        (bus.a),
        .b        (bb),
        .sum      (sum),
        .cout     (cout),
        .carry    (carry_q)
    );

    assign dbg = '{state: state, carry: carry_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sub_q     <= 1'b0;
            bus.s_out <= '0;
            bus.c_out <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
`ifdef SERIAL_OVF_EN
            bus.ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    bus.s_out <= {sum, bus.s_out[WIDTH-1:1]};
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        bus.c_out <= cout;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= ST_DONE;
`ifdef SERIAL_OVF_EN
                        // Carry into the MSB is the registered carry; carry out is cout.
                        bus.ovf   <= carry_q ^ cout;
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    bus.done <= 1'b0;
                    if (accept) begin
                        sub_q     <= bus.sub;
                        cnt       <= '0;
                        bus.c_out <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= ST_RUN;
`ifdef SERIAL_OVF_EN
                        bus.ovf   <= 1'b0;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_nbit.sv
// Directed and randomised checks of serial_addsub_nbit at WIDTH=4 using an
// expected-result queue filled at start and drained on each done pulse.
module tb_serial_addsub_nbit;
    import serial_arith_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    dbg_t dbg;

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_e;

    always #5 clk = ~clk;

    serial_addsub_nbit_if #(.WIDTH(W)) bus ();

    serial_addsub_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .dbg   (dbg)
    );

    // Packed as {ovf, c_out, s_out}.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = s ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, s};
        ov   = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op from the current cycle and ends on the done cycle.
    // glitch >= 0 pulses start (with sub inverted) during that bit of RUN.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s, input int glitch);
        logic [W+1:0] e;
        bus.start = 1'b1;
        bus.sub   = s;
        exp_q.push_back(model(av, bv, s));
        tick();
        chk("busy_run", 32'(bus.busy), 32'd1);
        chk("state_run", 32'(dbg.state), 32'(ST_RUN));
        chk("carry_init", 32'(dbg.carry), 32'(s));
        chk("c_out_clr", 32'(bus.c_out), 32'd0);
        bus.sub = ~s;
        for (int i = 0; i < W; i++) begin
            bus.a     = av[i];
            bus.b     = bv[i];
            bus.start = (i == glitch);
            tick();
            if (i < W - 1) chk("done_early", 32'(bus.done), 32'd0);
        end
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("state_done", 32'(dbg.state), 32'(ST_DONE));
        chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_e = e;
            chk("s_out", 32'(bus.s_out), 32'(e[W-1:0]));
            chk("c_out", 32'(bus.c_out), 32'(e[W]));
`ifdef SERIAL_OVF_EN
            chk("ovf", 32'(bus.ovf), 32'(e[W+1]));
`endif
        end
    endtask

    // One cycle after done with no new start: pulse gone, result held.
    task automatic idle_check();
        tick();
        chk("done_width", 32'(bus.done), 32'd0);
        chk("state_idle", 32'(dbg.state), 32'(ST_IDLE));
        chk("s_out_hold", 32'(bus.s_out), 32'(last_e[W-1:0]));
        chk("c_out_hold", 32'(bus.c_out), 32'(last_e[W]));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = 1'b0;
        bus.b     = 1'b0;
        last_e    = '0;
        repeat (3) tick();
        chk("rst_s_out", 32'(bus.s_out), 32'd0);
        chk("rst_c_out", 32'(bus.c_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("rst_carry", 32'(dbg.carry), 32'd0);
`ifdef SERIAL_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Directed cases, the two subtractions back-to-back.
        run_op(4'b1111, 4'b1010, 1'b0, -1);
        chk("add_1111_1010", 32'(bus.s_out), 32'b1001);
        idle_check();
        run_op(4'b1000, 4'b0011, 1'b1, -1);
        chk("sub_no_borrow", 32'(bus.c_out), 32'd1);
        run_op(4'b0011, 4'b1000, 1'b1, -1);
        chk("sub_borrow", 32'({bus.c_out, bus.s_out}), 32'b0_1011);
        idle_check();

        // Reset in the middle of a run.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.a = 1'b1;
            bus.b = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("abort_s_out", 32'(bus.s_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (4) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_op(4'b0001, 4'b0001, 1'b0, -1);
        chk("add_after_abort", 32'(bus.s_out), 32'b0010);
        idle_check();

        // start pulsed mid-run with the opposite mode is ignored.
        run_op(4'b0110, 4'b0011, 1'b0, 1);
        run_op(4'b0110, 4'b0011, 1'b1, 2);
        idle_check();

`ifdef SERIAL_OVF_EN
        run_op(4'b0111, 4'b0001, 1'b0, -1);
        chk("ovf_set", 32'({bus.ovf, bus.s_out}), 32'b1_1000);
        run_op(4'b0001, 4'b0001, 1'b0, -1);
        chk("ovf_clear", 32'(bus.ovf), 32'd0);
        idle_check();
`endif

        // Random back-to-back operations.
        for (int n = 0; n < 12; n++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, -1);
        end
        idle_check();

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
